// File: rtl/cm_block_feeder.sv
// Gathers 64-sample frames into eight 8-lane blocks for the complex multiplier.
// Short frames are zero-padded, and results still in flight are counted before the frame is closed.
module cm_block_feeder #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          cfg_stage,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_re,
  input  logic signed [W-1:0] in_im,
  input  logic                in_last,
  output logic                isValid,
  output logic [5:0]          start,
  output logic [5:0]          step,
  output logic signed [W-1:0] x  [0:7],
  output logic signed [W-1:0] xi [0:7],
  input  logic                resultValid,
  output logic                frame_done,
  output logic                frame_err,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, FILL, PAD, DRAIN} state_t;

  state_t              state, stateNext;
  logic [5:0]          sampleCnt, sampleCntNext;
  logic [2:0]          stage, stageEff;
  logic [2:0]          padBlk, padBlkNext;
  logic [3:0]          outstanding;
  logic signed [W-1:0] laneRe [0:7];
  logic signed [W-1:0] laneIm [0:7];
  logic signed [W-1:0] blkRe  [0:7];
  logic signed [W-1:0] blkIm  [0:7];
  logic                accept, issue, issueZero, errSet, doneNext, resultOk;
  logic [2:0]          lane, blk, issueBlk;

  function automatic logic [5:0] twStart(input logic [2:0] b, input logic [2:0] s);
    logic [5:0] t;
    t = {b, 3'b000};
    return t << s;
  endfunction

  function automatic logic [5:0] twStep(input logic [2:0] s);
    logic [5:0] one;
    one = 6'd1;
    return one << s;
  endfunction

  assign lane     = sampleCnt[2:0];
  assign blk      = sampleCnt[5:3];
  assign in_ready = !rst && (state == IDLE || state == FILL);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign resultOk = resultValid && (outstanding != 4'd0);

  // The first sample of a frame has to use the stage that is live on the port, because it is not latched yet
  assign stageEff = (state == IDLE) ? ((cfg_stage > 3'd5) ? 3'd5 : cfg_stage) : stage;

  always_comb begin
    stateNext     = state;
    sampleCntNext = sampleCnt;
    padBlkNext    = padBlk;
    issue         = 1'b0;
    issueZero     = 1'b0;
    issueBlk      = blk;
    errSet        = 1'b0;
    doneNext      = 1'b0;
    case (state)
      IDLE, FILL: begin
        if (accept) begin
          sampleCntNext = sampleCnt + 6'd1;
          if (sampleCnt == 6'd63) begin
            issue     = 1'b1;
            stateNext = DRAIN;
            errSet    = !in_last;
          end else if (in_last) begin
            issue         = 1'b1;
            errSet        = 1'b1;
            sampleCntNext = 6'd0;
            if (blk == 3'd7) begin
              stateNext = DRAIN;
            end else begin
              stateNext  = PAD;
              padBlkNext = blk + 3'd1;
            end
          end else begin
            stateNext = FILL;
            issue     = (lane == 3'd7);
          end
        end
      end
      PAD: begin
        issue      = 1'b1;
        issueZero  = 1'b1;
        issueBlk   = padBlk;
        padBlkNext = padBlk + 3'd1;
        if (padBlk == 3'd7) stateNext = DRAIN;
      end
      DRAIN: begin
        // isValid still high means one increment of the counter has not landed yet
        if (outstanding == 4'd0 && !isValid) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Lanes already stored come from the registers, the current lane comes straight from the input, and the rest are zero
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      blkRe[k] = '0;
      blkIm[k] = '0;
      if (!issueZero) begin
        if (3'(k) < lane) begin
          blkRe[k] = laneRe[k];
          blkIm[k] = laneIm[k];
        end else if (3'(k) == lane) begin
          blkRe[k] = in_re;
          blkIm[k] = in_im;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sampleCnt   <= '0;
      stage       <= '0;
      padBlk      <= '0;
      outstanding <= '0;
      isValid     <= 1'b0;
      start       <= '0;
      step        <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        x[k]      <= '0;
        xi[k]     <= '0;
        laneRe[k] <= '0;
        laneIm[k] <= '0;
      end
    end else begin
      state      <= stateNext;
      sampleCnt  <= sampleCntNext;
      padBlk     <= padBlkNext;
      isValid    <= issue;
      frame_done <= doneNext;
      if (state == IDLE && accept) stage <= stageEff;
      if (accept) begin
        laneRe[lane] <= in_re;
        laneIm[lane] <= in_im;
      end
      if (issue) begin
        start <= twStart(issueBlk, stageEff);
        step  <= twStep(stageEff);
        for (int k = 0; k < 8; k++) begin
          x[k]  <= blkRe[k];
          xi[k] <= blkIm[k];
        end
      end
      if (isValid && !resultOk) outstanding <= outstanding + 4'd1;
      else if (!isValid && resultOk) outstanding <= outstanding - 4'd1;
      if (errSet || (resultValid && outstanding == 4'd0)) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cm_block_feeder.sv
// Randomised frame bench for cm_block_feeder. The expected blocks, issue cycles and
// frame_done timing are worked out from per-frame sample arrays in plain arithmetic.
module tb_cm_block_feeder;
  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic [2:0]          cfg_stage;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_re;
  logic signed [W-1:0] in_im;
  logic                in_last;
  logic                isValid;
  logic [5:0]          start;
  logic [5:0]          step;
  logic signed [W-1:0] x  [0:7];
  logic signed [W-1:0] xi [0:7];
  logic                resultValid;
  logic                frame_done;
  logic                frame_err;
  logic                busy;

  cm_block_feeder #(.W(W)) dut (
    .clk(clk), .rst(rst), .cfg_stage(cfg_stage), .in_valid(in_valid),
    .in_ready(in_ready), .in_re(in_re), .in_im(in_im), .in_last(in_last),
    .isValid(isValid), .start(start), .step(step), .x(x), .xi(xi),
    .resultValid(resultValid), .frame_done(frame_done), .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    logic [5:0]   st;
    logic [5:0]   sp;
    logic [127:0] re;
    logic [127:0] im;
  } blk_t;

  blk_t                expQ[$];
  int                  checks = 0;
  int                  failures = 0;
  int                  cyc = 0;
  bit                  rvEnable = 1'b1;
  bit                  rvForce = 1'b0;
  bit                  lastIv = 1'b0;
  bit                  mErr = 1'b0;
  bit                  holdOn = 1'b0;
  logic [127:0]        heldRe, heldIm;
  logic [11:0]         heldTw;
  logic signed [W-1:0] smpRe [0:63];
  logic signed [W-1:0] smpIm [0:63];

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic blk_t mkBlk(int b, int s, int lastN, int due);
    blk_t e;
    e.due = due;
    e.st  = 6'((b * 8 * (1 << s)) % 64);
    e.sp  = 6'((1 << s) % 64);
    for (int j = 0; j < 8; j++) begin
      e.re[127-16*j -: 16] = (8*b + j <= lastN) ? smpRe[8*b + j] : '0;
      e.im[127-16*j -: 16] = (8*b + j <= lastN) ? smpIm[8*b + j] : '0;
    end
    return e;
  endfunction

  // Runs one clock: drives the multiplier responder, then compares any issued block against the queue head
  task automatic tick();
    blk_t         e;
    logic [127:0] oRe, oIm;
    @(posedge clk);
    #1;
    cyc++;
    resultValid = (rvEnable && lastIv) || rvForce;
    lastIv      = rvEnable && isValid;
    for (int k = 0; k < 8; k++) begin
      oRe[127-16*k -: 16] = x[k];
      oIm[127-16*k -: 16] = xi[k];
    end
    if (isValid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_block", 128'(isValid), 128'(0));
      end else begin
        e = expQ.pop_front();
        checkOutput("issue_cycle", 128'(cyc), 128'(e.due));
        checkOutput("start_step", 128'({start, step}), 128'({e.st, e.sp}));
        checkOutput("lanes_re", oRe, e.re);
        checkOutput("lanes_im", oIm, e.im);
        heldRe = e.re;
        heldIm = e.im;
        heldTw = {e.st, e.sp};
      end
    end else if (holdOn) begin
      checkOutput("hold_lanes", oRe ^ oIm, heldRe ^ heldIm);
      checkOutput("hold_tw", 128'({start, step}), 128'(heldTw));
    end
  endtask

  task automatic doReset(input int cycles);
    logic [127:0] oRe, oIm;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    rvEnable = 1'b0;
    holdOn = 1'b0;
    #1;
    checkOutput("ready_in_rst", 128'(in_ready), 128'(0));
    repeat (cycles) tick();
    rst = 1'b0;
    rvEnable = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      oRe[127-16*k -: 16] = x[k];
      oIm[127-16*k -: 16] = xi[k];
    end
    checkOutput("rst_lanes", oRe | oIm, 128'(0));
    checkOutput("rst_ctrl", 128'({isValid, start, step, frame_done, frame_err, busy}), 128'(0));
    checkOutput("ready_after_rst", 128'(in_ready), 128'(1));
    mErr = 1'b0;
    expQ.delete();
    heldRe = '0;
    heldIm = '0;
    heldTw = '0;
    holdOn = 1'b1;
  endtask

  task automatic fillSamples(input bit directed);
    for (int n = 0; n < 64; n++) begin
      smpRe[n] = directed ? 16'(n)  : 16'($urandom);
      smpIm[n] = directed ? 16'(-n) : 16'($urandom);
    end
  endtask

  // Drives sample n for one accept cycle and queues the blocks that this accept is expected to release
  task automatic driveSample(input int n, input int stageCfg, input int lastN, input bit withLast, output int lastDue);
    int s;
    s = (stageCfg > 5) ? 5 : stageCfg;
    lastDue = 0;
    in_valid  = 1'b1;
    in_re     = smpRe[n];
    in_im     = smpIm[n];
    in_last   = withLast && (n == lastN);
    cfg_stage = (n == 0) ? 3'(stageCfg) : 3'($urandom_range(0, 7));
    #1;
    checkOutput("in_ready_fill", 128'(in_ready), 128'(1));
    if (n == lastN) begin
      for (int b = n / 8; b < 8; b++) expQ.push_back(mkBlk(b, s, lastN, cyc + 1 + (b - n / 8)));
      lastDue = cyc + 1 + (7 - n / 8);
    end else if (n % 8 == 7) begin
      expQ.push_back(mkBlk(n / 8, s, lastN, cyc + 1));
    end
    tick();
  endtask

  task automatic applyStimulus(input int stageCfg, input int lastN, input bit withLast, input bit gapped);
    int lastDue, d;
    lastDue = 0;
    for (int n = 0; n <= lastN; n++) begin
      if (gapped) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          in_last  = 1'b0;
          tick();
        end
      end
      driveSample(n, stageCfg, lastN, withLast, d);
      if (n == lastN) lastDue = d;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (lastN < 63 || !withLast) mErr = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (frame_done) break;
      checkOutput("in_ready_busy", 128'(in_ready), 128'(0));
      tick();
    end
    checkOutput("done_cycle", 128'(cyc), 128'(lastDue + 3));
    checkOutput("idle_ready", 128'({in_ready, busy}), 128'(2'b10));
    checkOutput("frame_err", 128'(frame_err), 128'(mErr));
    checkOutput("blocks_left", 128'(expQ.size()), 128'(0));
    tick();
    checkOutput("done_pulse", 128'(frame_done), 128'(0));
  endtask

  initial begin
    int d;
    rst = 1'b1;
    cfg_stage = '0;
    in_valid = 1'b0;
    in_re = '0;
    in_im = '0;
    in_last = 1'b0;
    resultValid = 1'b0;
    heldRe = '0;
    heldIm = '0;
    heldTw = '0;
    doReset(3);

    fillSamples(1'b1); applyStimulus(0, 63, 1'b1, 1'b0);
    fillSamples(1'b0); applyStimulus(2, 63, 1'b1, 1'b0);
    fillSamples(1'b0); applyStimulus(7, 63, 1'b1, 1'b1);
    fillSamples(1'b1); applyStimulus(1, 10, 1'b1, 1'b0);
    doReset(1);
    fillSamples(1'b0); applyStimulus(3, 31, 1'b1, 1'b1);
    doReset(2);
    fillSamples(1'b0); applyStimulus(4, 63, 1'b0, 1'b0);
    doReset(1);
    fillSamples(1'b0); applyStimulus(5, 60, 1'b1, 1'b0);
    doReset(1);

    // Abandon a frame part-way through, then check that the next one starts again from block 0
    fillSamples(1'b0);
    for (int n = 0; n < 20; n++) driveSample(n, 2, 63, 1'b1, d);
    in_valid = 1'b0;
    tick();
    checkOutput("q_before_rst", 128'(expQ.size()), 128'(0));
    doReset(1);
    fillSamples(1'b1); applyStimulus(1, 63, 1'b1, 1'b0);

    // A result strobe that nothing is waiting for
    rvForce = 1'b1;
    tick();
    rvForce = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("no_done_idle", 128'({frame_done, busy}), 128'(0));
    end
    mErr = 1'b1;
    checkOutput("err_spurious", 128'(frame_err), 128'(mErr));
    fillSamples(1'b0); applyStimulus(5, 63, 1'b1, 1'b1);

    for (int r = 0; r < 3; r++) begin
      fillSamples(1'b0);
      applyStimulus(int'($urandom_range(0, 7)), 63, 1'b1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
